// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the cache refill path.
//   - state_e       : refill FSM state encoding
//   - DEF_TAG_W     : default tag width (matches the tag comparator)
//   - DEF_INDEX_W   : default set index width (8 direct-mapped lines)
//   - DEF_BLOCK_W   : default block width in bits
//   - block_addr_w(): width of a block address {tag,index}
// -----------------------------------------------------------------------------
package cache_pkg;

    localparam int DEF_TAG_W   = 3;
    localparam int DEF_INDEX_W = 3;
    localparam int DEF_BLOCK_W = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        UPDATE    = 2'd3
    } state_e;

    // Memory is block addressed, so the address is just the tag and index.
    function automatic int block_addr_w(input int tag_w, input int index_w);
        return tag_w + index_w;
    endfunction

endpackage

// File: rtl/cache_refill_controller.sv
// -----------------------------------------------------------------------------
// cache_refill_controller
// Miss-side partner of the tag comparison path. On a miss it writes a dirty
// victim back to data memory, fetches the requested block, then issues a
// single fill strobe that writes tag/valid/dirty/data for the line. The CPU
// is stalled for the whole refill. All outputs are registered (Moore FSM).
//
// Ports
//   clock, reset        : system clock; synchronous active-high reset
//   miss_req            : miss from hit logic (sampled in IDLE only)
//   req_tag, req_index  : requested address
//   victim_tag/dirty/data : current contents of the line at req_index
//   mem_read, mem_write : data memory requests (never both high)
//   mem_address         : block address {tag,index}
//   mem_writedata       : write-back block
//   mem_readdata        : fetched block
//   mem_busywait        : memory busy handshake
//   fill_we             : one-cycle write strobe into tag/data arrays
//   fill_index, fill_tag, fill_data : line, tag and block to write
//   cpu_stall           : busywait to the CPU
// -----------------------------------------------------------------------------
module cache_refill_controller
    import cache_pkg::*;
#(
    parameter  int TAG_W   = DEF_TAG_W,
    parameter  int INDEX_W = DEF_INDEX_W,
    parameter  int BLOCK_W = DEF_BLOCK_W,
    localparam int ADDR_W  = block_addr_w(TAG_W, INDEX_W)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               miss_req,
    input  logic [TAG_W-1:0]   req_tag,
    input  logic [INDEX_W-1:0] req_index,
    input  logic [TAG_W-1:0]   victim_tag,
    input  logic               victim_dirty,
    input  logic [BLOCK_W-1:0] victim_data,
    output logic               mem_read,
    output logic               mem_write,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [BLOCK_W-1:0] mem_writedata,
    input  logic [BLOCK_W-1:0] mem_readdata,
    input  logic               mem_busywait,
    output logic               fill_we,
    output logic [INDEX_W-1:0] fill_index,
    output logic [TAG_W-1:0]   fill_tag,
    output logic [BLOCK_W-1:0] fill_data,
    output logic               cpu_stall
);

    state_e               state_q,         state_d;
    logic                 mem_read_q,      mem_read_d;
    logic                 mem_write_q,     mem_write_d;
    logic [ADDR_W-1:0]    mem_address_q,   mem_address_d;
    logic [BLOCK_W-1:0]   mem_writedata_q, mem_writedata_d;
    logic [TAG_W-1:0]     req_tag_q,       req_tag_d;
    logic [INDEX_W-1:0]   index_q,         index_d;
    logic [BLOCK_W-1:0]   fill_data_q,     fill_data_d;
    logic                 fill_we_q,       fill_we_d;
    logic                 cpu_stall_q,     cpu_stall_d;
    logic                 seen_busy_q,     seen_busy_d;

    logic                 mem_phase;
    logic                 handshake_done;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
            req_tag_q       <= '0;
            index_q         <= '0;
            fill_data_q     <= '0;
            fill_we_q       <= 1'b0;
            cpu_stall_q     <= 1'b0;
            seen_busy_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
            req_tag_q       <= req_tag_d;
            index_q         <= index_d;
            fill_data_q     <= fill_data_d;
            fill_we_q       <= fill_we_d;
            cpu_stall_q     <= cpu_stall_d;
            seen_busy_q     <= seen_busy_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        mem_read_d      = mem_read_q;
        mem_write_d     = mem_write_q;
        mem_address_d   = mem_address_q;
        mem_writedata_d = mem_writedata_q;
        req_tag_d       = req_tag_q;
        index_d         = index_q;
        fill_data_d     = fill_data_q;
        fill_we_d       = 1'b0;
        cpu_stall_d     = cpu_stall_q;
        seen_busy_d     = seen_busy_q;

        // Shared memory handshake. The request is only complete once busywait
        // has been seen high and has dropped again; a memory that is slow to
        // raise busywait therefore cannot cause an early exit.
        mem_phase      = (state_q == WRITEBACK) || (state_q == FETCH);
        handshake_done = mem_phase && seen_busy_q && !mem_busywait;
        if (mem_phase) begin
            seen_busy_d = handshake_done ? 1'b0 : (seen_busy_q | mem_busywait);
        end

        unique case (state_q)
            IDLE: begin
                if (miss_req) begin
                    req_tag_d   = req_tag;
                    index_d     = req_index;
                    cpu_stall_d = 1'b1;
                    // The victim is captured straight into the memory request
                    // registers, so later changes on victim_* are irrelevant.
                    if (victim_dirty) begin
                        state_d         = WRITEBACK;
                        mem_write_d     = 1'b1;
                        mem_address_d   = {victim_tag, req_index};
                        mem_writedata_d = victim_data;
                    end else begin
                        state_d       = FETCH;
                        mem_read_d    = 1'b1;
                        mem_address_d = {req_tag, req_index};
                    end
                end
            end

            WRITEBACK: begin
                if (handshake_done) begin
                    // Switch directly from write to read on the same edge;
                    // the two strobes are never high together.
                    state_d       = FETCH;
                    mem_write_d   = 1'b0;
                    mem_read_d    = 1'b1;
                    mem_address_d = {req_tag_q, index_q};
                end
            end

            FETCH: begin
                if (handshake_done) begin
                    state_d     = UPDATE;
                    mem_read_d  = 1'b0;
                    fill_data_d = mem_readdata;
                    fill_we_d   = 1'b1;
                end
            end

            UPDATE: begin
                // fill_we is high for this single cycle; release the CPU as
                // the line becomes valid.
                state_d     = IDLE;
                cpu_stall_d = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign mem_address   = mem_address_q;
    assign mem_writedata = mem_writedata_q;
    assign fill_we       = fill_we_q;
    assign fill_index    = index_q;
    assign fill_tag      = req_tag_q;
    assign fill_data     = fill_data_q;
    assign cpu_stall     = cpu_stall_q;

endmodule

// File: tb/tb_cache_refill_controller.sv
// -----------------------------------------------------------------------------
// tb_cache_refill_controller
// Scoreboarded bench: each miss pushes the memory transactions, fill and
// refill latency it should produce; a negedge monitor pops and compares them.
// A simple memory model drives busywait combinationally from the request:
// low for mem_delay cycles, then high for mem_busy cycles, then low.
// -----------------------------------------------------------------------------
module tb_cache_refill_controller;

    localparam int TAG_W   = 3;
    localparam int INDEX_W = 3;
    localparam int BLOCK_W = 32;

    localparam logic [1:0] K_RD   = 2'b01;
    localparam logic [1:0] K_WR   = 2'b10;
    localparam logic [1:0] K_FILL = 2'b11;

    typedef struct {
        logic [1:0]  kind;
        logic [5:0]  addr;
        logic [31:0] data;
    } txn_t;

    logic               clock = 1'b0;
    logic               reset;
    logic               miss_req;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]   victim_tag;
    logic               victim_dirty;
    logic [BLOCK_W-1:0] victim_data;
    logic               mem_read;
    logic               mem_write;
    logic [5:0]         mem_address;
    logic [BLOCK_W-1:0] mem_writedata;
    logic [BLOCK_W-1:0] mem_readdata;
    logic               mem_busywait;
    logic               fill_we;
    logic [INDEX_W-1:0] fill_index;
    logic [TAG_W-1:0]   fill_tag;
    logic [BLOCK_W-1:0] fill_data;
    logic               cpu_stall;

    int n_checks = 0;
    int n_errors = 0;

    txn_t exp_q[$];
    int   lat_q[$];

    int mem_delay = 0;
    int mem_busy  = 1;
    int mcnt      = 0;

    logic [1:0]  prev_kind   = 2'b00;
    logic        prev_fill   = 1'b0;
    logic        prev_stall  = 1'b0;
    int          stall_cnt   = 0;
    int          fill_cnt    = 0;
    logic [5:0]  snap_addr   = '0;
    logic [31:0] snap_data   = '0;

    always #5 clock = ~clock;

    cache_refill_controller #(
        .TAG_W   (TAG_W),
        .INDEX_W (INDEX_W),
        .BLOCK_W (BLOCK_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .miss_req      (miss_req),
        .req_tag       (req_tag),
        .req_index     (req_index),
        .victim_tag    (victim_tag),
        .victim_dirty  (victim_dirty),
        .victim_data   (victim_data),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait),
        .fill_we       (fill_we),
        .fill_index    (fill_index),
        .fill_tag      (fill_tag),
        .fill_data     (fill_data),
        .cpu_stall     (cpu_stall)
    );

    // Memory model: mcnt counts cycles of the current request and restarts
    // at the edge where the busy window has closed (the request completes).
    assign mem_busywait = (mem_read || mem_write) && (mcnt >= mem_delay) &&
                          (mcnt < mem_delay + mem_busy);

    always @(posedge clock) begin
        if (!(mem_read || mem_write))
            mcnt <= 0;
        else if (mcnt >= mem_delay + mem_busy)
            mcnt <= 0;
        else
            mcnt <= mcnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: compares transaction starts and fills against the scoreboard,
    // checks request stability, strobe exclusivity and refill latency.
    always @(negedge clock) begin : mon
        txn_t t;
        if (reset) begin
            prev_kind  <= 2'b00;
            prev_fill  <= 1'b0;
            prev_stall <= 1'b0;
            stall_cnt  <= 0;
        end else begin
            chk("rw_excl", {63'd0, mem_read & mem_write}, 64'd0);
            if ({mem_write, mem_read} != 2'b00) begin
                if ({mem_write, mem_read} != prev_kind) begin
                    chk("sb_pending_req", {63'd0, exp_q.size() > 0}, 64'd1);
                    if (exp_q.size() > 0) begin
                        t = exp_q.pop_front();
                        chk("req_kind_addr", {56'd0, mem_write, mem_read, mem_address},
                            {56'd0, t.kind, t.addr});
                        if (t.kind == K_WR)
                            chk("wb_data", {32'd0, mem_writedata}, {32'd0, t.data});
                    end
                    snap_addr <= mem_address;
                    snap_data <= mem_writedata;
                end else begin
                    chk("req_addr_stable", {58'd0, mem_address}, {58'd0, snap_addr});
                    if (mem_write)
                        chk("wb_data_stable", {32'd0, mem_writedata}, {32'd0, snap_data});
                end
            end
            if (fill_we) begin
                fill_cnt <= fill_cnt + 1;
                chk("fill_pulse", {63'd0, prev_fill}, 64'd0);
                chk("fill_stall", {63'd0, cpu_stall}, 64'd1);
                chk("sb_pending_fill", {63'd0, exp_q.size() > 0}, 64'd1);
                if (exp_q.size() > 0) begin
                    t = exp_q.pop_front();
                    chk("fill_tag_idx", {56'd0, K_FILL, fill_tag, fill_index},
                        {56'd0, t.kind, t.addr});
                    chk("fill_data", {32'd0, fill_data}, {32'd0, t.data});
                end
            end
            if (cpu_stall)
                stall_cnt <= stall_cnt + 1;
            if (prev_stall && !cpu_stall) begin
                chk("sb_pending_lat", {63'd0, lat_q.size() > 0}, 64'd1);
                // Latency includes the IDLE cycle that accepts the miss.
                if (lat_q.size() > 0)
                    chk("latency", 64'(stall_cnt + 1), 64'(lat_q.pop_front()));
                stall_cnt <= 0;
            end
            prev_kind  <= {mem_write, mem_read};
            prev_fill  <= fill_we;
            prev_stall <= cpu_stall;
        end
    end

    // Present a miss for one cycle and push what it should produce. With
    // full=0 only the first memory transaction is expected (aborted refill).
    task automatic do_miss(input logic [2:0] tag, input logic [2:0] idx,
                           input logic [2:0] vtag, input logic vd,
                           input logic [31:0] vdata, input logic [31:0] rdata,
                           input int d, input int b, input bit full);
        txn_t t;
        mem_delay    = d;
        mem_busy     = b;
        mem_readdata = rdata;
        miss_req     = 1'b1;
        req_tag      = tag;
        req_index    = idx;
        victim_tag   = vtag;
        victim_dirty = vd;
        victim_data  = vdata;
        if (vd) begin
            t.kind = K_WR; t.addr = {vtag, idx}; t.data = vdata;
            exp_q.push_back(t);
        end
        if (full || !vd) begin
            t.kind = K_RD; t.addr = {tag, idx}; t.data = '0;
            exp_q.push_back(t);
        end
        if (full) begin
            t.kind = K_FILL; t.addr = {tag, idx}; t.data = rdata;
            exp_q.push_back(t);
            lat_q.push_back(2 + (vd ? 2 : 1) * (d + b + 1));
        end
        @(posedge clock); #1;
        miss_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (cpu_stall && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        chk("idle_timeout", {63'd0, cpu_stall}, 64'd0);
    endtask

    initial begin
        int fc;
        reset        = 1'b1;
        miss_req     = 1'b0;
        req_tag      = '0;
        req_index    = '0;
        victim_tag   = '0;
        victim_dirty = 1'b0;
        victim_data  = '0;
        mem_readdata = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ctrl", {60'd0, mem_read, mem_write, fill_we, cpu_stall}, 64'd0);
        chk("rst_addr_data", {26'd0, mem_address, mem_writedata}, 64'd0);
        chk("rst_fill", {26'd0, fill_tag, fill_index, fill_data}, 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // 1: clean miss, busy 4 cycles
        do_miss(3'b101, 3'b010, 3'b000, 1'b0, 32'h0, 32'hA5A5_0F0F, 0, 4, 1'b1);
        wait_idle();
        repeat (2) @(posedge clock); #1;

        // 2: dirty miss
        do_miss(3'b110, 3'b111, 3'b011, 1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 0, 3, 1'b1);
        wait_idle();
        repeat (2) @(posedge clock); #1;

        // 3: reset two cycles into WRITEBACK
        fc = fill_cnt;
        do_miss(3'b010, 3'b001, 3'b100, 1'b1, 32'hCAFE_0001, 32'h1111_2222, 0, 5, 1'b0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        chk("rst_mid_ctrl", {60'd0, mem_read, mem_write, fill_we, cpu_stall}, 64'd0);
        reset = 1'b0;
        repeat (10) @(posedge clock); #1;
        chk("rst_mid_nofill", 64'(fill_cnt - fc), 64'd0);
        chk("rst_mid_idle", {62'd0, mem_read, mem_write}, 64'd0);

        // 4: inputs toggled during FETCH are ignored
        fc = fill_cnt;
        do_miss(3'b001, 3'b100, 3'b010, 1'b0, 32'h0, 32'h1234_5678, 0, 6, 1'b1);
        for (int i = 0; i < 3; i++) begin
            miss_req     = 1'b1;
            victim_dirty = 1'b1;
            victim_tag   = 3'b111;
            victim_data  = $urandom;
            req_tag      = 3'(i + 2);
            req_index    = 3'(i + 5);
            @(posedge clock); #1;
        end
        miss_req = 1'b0;
        wait_idle();
        repeat (2) @(posedge clock); #1;
        chk("one_fill", 64'(fill_cnt - fc), 64'd1);

        // 5: back-to-back misses, second asserted in first IDLE cycle
        do_miss(3'b011, 3'b011, 3'b101, 1'b1, 32'h5555_AAAA, 32'h7777_8888, 0, 2, 1'b1);
        wait_idle();
        do_miss(3'b100, 3'b110, 3'b001, 1'b0, 32'h0, 32'h9999_0000, 0, 1, 1'b1);
        wait_idle();
        repeat (2) @(posedge clock); #1;

        // 6: busywait rises 3 cycles after the request
        do_miss(3'b111, 3'b000, 3'b010, 1'b1, 32'h0F0F_F0F0, 32'hFEED_FACE, 3, 2, 1'b1);
        wait_idle();
        repeat (2) @(posedge clock); #1;

        // a few random refills
        for (int i = 0; i < 4; i++) begin
            do_miss(3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom),
                    $urandom, $urandom, int'($urandom_range(0, 2)),
                    int'($urandom_range(1, 4)), 1'b1);
            wait_idle();
            @(posedge clock); #1;
        end

        repeat (3) @(posedge clock); #1;
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        chk("lat_empty", 64'(lat_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
